mult_div_unit: RTL

//  Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the E stage beside the ALU.

---
 rtl/md_pkg.sv | 26 ++
 rtl/md_arith.sv | 74 +++++++
 rtl/mult_div_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared opcode and HI/LO write-enable encodings for the multiply/divide unit.
// The controller's multctrl/muwe decode uses the same constants.
package md_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MADD  = 3'd4;
   localparam logic [2:0] MD_MADDU = 3'd5;
   localparam logic [2:0] MD_MSUB  = 3'd6;
   localparam logic [2:0] MD_MSUBU = 3'd7;

   localparam logic [1:0] WE_NONE  = 2'b00;
   localparam logic [1:0] WE_HI    = 2'b01;
   localparam logic [1:0] WE_LO    = 2'b10;

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational result calculator: full-width product/accumulate and
// sign-corrected division; a zero divisor returns the current HI/LO.
module md_arith
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo,
   output logic             div0
);

   localparam int W2 = 2 * WIDTH;

   logic             sgn;
   logic [W2-1:0]    op_a;
   logic [W2-1:0]    op_b;
   logic [W2-1:0]    prod;
   logic [W2-1:0]    acc;
   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quot_u;
   logic [WIDTH-1:0] rem_u;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;

   always_comb begin
      sgn  = is_signed_op(op);
      // Sign-extending to 2*WIDTH lets one truncated multiplier serve both signednesses.
      op_a = sgn ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
      op_b = sgn ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
      prod = op_a * op_b;
      acc  = {hi, lo};
   end

   always_comb begin
      neg_a   = sgn & d1[WIDTH-1];
      neg_b   = sgn & d2[WIDTH-1];
      mag_a   = neg_a ? -d1 : d1;
      mag_b   = neg_b ? -d2 : d2;
      div0    = is_div_op(op) && (d2 == '0);
      divisor = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
      quot_u  = mag_a / divisor;
      rem_u   = mag_a % divisor;
      // MIN/-1 falls out naturally: |MIN| wraps to MIN, and negating it again gives MIN.
      quot    = (neg_a ^ neg_b) ? -quot_u : quot_u;
      rem     = neg_a ? -rem_u : rem_u;
   end

   always_comb begin
      {res_hi, res_lo} = acc;
      case (op)
         MD_MULT, MD_MULTU: {res_hi, res_lo} = prod;
         MD_MADD, MD_MADDU: {res_hi, res_lo} = acc + prod;
         MD_MSUB, MD_MSUBU: {res_hi, res_lo} = acc - prod;
         MD_DIV, MD_DIVU: begin
            if (!div0) begin
               res_hi = rem;
               res_lo = quot;
            end
         end
         default: {res_hi, res_lo} = acc;
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO: the result is computed at launch,
// held in pending registers, and committed when the latency counter expires.
module mult_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       md_op,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [1:0]       we,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
   logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
   logic             div0_q, div0_d;
   logic             busy_w;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic             res_div0;

   md_arith #(
      .WIDTH(WIDTH)
   ) u_arith (
      .op    (md_op),
      .d1    (d1),
      .d2    (d2),
      .hi    (hi_q),
      .lo    (lo_q),
      .res_hi(res_hi),
      .res_lo(res_lo),
      .div0  (res_div0)
   );

   // busy decodes only the counter, so start/md_op never reach it combinationally.
   assign busy_w = (cnt_q != '0);

   // Priority: flush, then the in-flight op, then a new launch, then mthi/mtlo.
   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      div0_d    = div0_q;
      if (flush) begin
         cnt_d = '0;
      end else if (busy_w) begin
         if (cnt_q == CNT_ONE) begin
            cnt_d = '0;
            if (!div0_q) begin
               hi_d = pend_hi_q;
               lo_d = pend_lo_q;
            end
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end else if (start) begin
         pend_hi_d = res_hi;
         pend_lo_d = res_lo;
         div0_d    = res_div0;
         cnt_d     = is_div_op(md_op) ? DIV_CNT : MULT_CNT;
      end else if (we == WE_HI) begin
         hi_d = d1;
      end else if (we == WE_LO) begin
         lo_d = d1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         div0_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         div0_q    <= div0_d;
      end
   end

   assign busy = busy_w;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
